// File: rtl/adam_aes_encipher_block.sv
// Iterative AES encipher round engine: one shared S-box lookup per cycle,
// four lookups per round, then a combined ShiftRows/MixColumns/AddRoundKey step.
module adam_aes_encipher_block (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] w_q [4];
    logic [31:0] w_d [4];
    logic [3:0]  round_q, round_d;
    logic [1:0]  sword_ctr_q, sword_ctr_d;
    logic        ready_q, ready_d;
    logic        keylen_q, keylen_d;

    logic [127:0] state_vec, sr_vec, mc_vec, main_vec;
    logic [3:0]   nr;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of the state sits at bits [127-8k -: 8]; column c, row r is k = 4c + r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    assign state_vec = {w_q[0], w_q[1], w_q[2], w_q[3]};
    assign sr_vec    = shift_rows(state_vec);
    assign mc_vec    = {mix_word(sr_vec[127:96]), mix_word(sr_vec[95:64]),
                        mix_word(sr_vec[63:32]),  mix_word(sr_vec[31:0])};
    assign nr        = keylen_q ? 4'd14 : 4'd10;
    assign main_vec  = ((round_q < nr) ? mc_vec : sr_vec) ^ round_key;

    // NOTE: every signal assigned here gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        round_d     = round_q;
        sword_ctr_d = sword_ctr_q;
        ready_d     = ready_q;
        keylen_d    = keylen_q;
        sboxw       = '0;

        unique case (state_q)
            IDLE: begin
                if (next) begin
                    round_d  = 4'd0;
                    ready_d  = 1'b0;
                    keylen_d = keylen;
                    state_d  = INIT;
                end
            end
            INIT: begin
                {w_d[0], w_d[1], w_d[2], w_d[3]} = block ^ round_key;
                round_d     = 4'd1;
                sword_ctr_d = 2'd0;
                state_d     = SBOX;
            end
            SBOX: begin
                sboxw            = w_q[sword_ctr_q];
                w_d[sword_ctr_q] = new_sboxw;
                sword_ctr_d      = sword_ctr_q + 2'd1;
                if (sword_ctr_q == 2'd3) begin
                    state_d = MAIN;
                end
            end
            MAIN: begin
                {w_d[0], w_d[1], w_d[2], w_d[3]} = main_vec;
                sword_ctr_d = 2'd0;
                if (round_q < nr) begin
                    round_d = round_q + 4'd1;
                    state_d = SBOX;
                end else begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            // NOTE: the word array is cleared on reset because new_block must read zero after reset.
            w_q         <= '{default: '0};
            round_q     <= 4'd0;
            sword_ctr_q <= 2'd0;
            ready_q     <= 1'b1;
            keylen_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            round_q     <= round_d;
            sword_ctr_q <= sword_ctr_d;
            ready_q     <= ready_d;
            keylen_q    <= keylen_d;
        end
    end

    assign round     = round_q;
    assign new_block = state_vec;
    assign ready     = ready_q;

endmodule

// File: tb/tb_adam_aes_encipher_block.sv
// Self-checking bench: FIPS-197 vectors plus random blocks against a byte-level AES model;
// the S-box and key schedule are derived from GF(2^8) arithmetic inside the bench.
module tb_adam_aes_encipher_block;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] rk_tab   [16];

    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    always #5 clk = ~clk;

    adam_aes_encipher_block dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    assign round_key = rk_tab[round];
    assign new_sboxw = {sbox_tab[sboxw[31:24]], sbox_tab[sboxw[23:16]],
                        sbox_tab[sboxw[15:8]],  sbox_tab[sboxw[7:0]]};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [255:0] key, input bit kl);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rcon = 8'h01;
        int nk = kl ? 8 : 4;
        int nr = kl ? 14 : 10;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r < 16; r++)
            rk_tab[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // Byte-level reference cipher on a column-major 16-byte state.
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] out;
        for (int k = 0; k < 16; k++) s[k] = pt[127 - 8*k -: 8] ^ rk_tab[0][127 - 8*k -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox_tab[s[k]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c + r] = s[4*((c + r) % 4) + r];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c + r] = (rnd < nr)
                        ? gmul(8'h02, t[4*c + r]) ^ gmul(8'h03, t[4*c + (r+1) % 4])
                          ^ t[4*c + (r+2) % 4] ^ t[4*c + (r+3) % 4]
                        : t[4*c + r];
            for (int k = 0; k < 16; k++) s[k] ^= rk_tab[rnd][127 - 8*k -: 8];
        end
        for (int k = 0; k < 16; k++) out[127 - 8*k -: 8] = s[k];
        return out;
    endfunction

    task automatic run_op(input string tag, input logic [255:0] key, input bit kl,
                          input logic [127:0] pt, input logic [127:0] exp,
                          input int pulse_at, input bit toggle_kl);
        int cyc = 0;
        expand_key(key, kl);
        @(posedge clk); #1;
        block  = pt;
        keylen = kl;
        next   = 1'b1;
        @(posedge clk); #1;
        next = 1'b0;
        check({tag, "_busy"}, 128'(ready), 128'd0);
        while (cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (ready) break;
            next = (cyc == pulse_at);
            if (toggle_kl && (cyc % 7 == 0)) keylen = ~keylen;
            block = 128'($urandom);
        end
        next = 1'b0;
        check({tag, "_latency"}, 128'(cyc), 128'(kl ? 71 : 51));
        check({tag, "_result"}, new_block, exp);
        check({tag, "_round"}, 128'(round), 128'(kl ? 14 : 10));
    endtask

    initial begin
        reset_n = 1'b0;
        next    = 1'b0;
        keylen  = 1'b0;
        block   = '0;
        build_sbox();
        expand_key(KEY_C1, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", 128'(ready), 128'd1);
        check("rst_round", 128'(round), 128'd0);
        check("rst_block", new_block, 128'd0);
        check("rst_sboxw", 128'(sboxw), 128'd0);

        run_op("c1", KEY_C1, 1'b0, PT, CT_C1, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("c1_hold", new_block, CT_C1);
        run_op("c3", KEY_C3, 1'b1, PT, CT_C3, 0, 1'b0);
        run_op("c1_disturb", KEY_C1, 1'b0, PT, CT_C1, 10, 1'b1);

        // Abort mid-operation with reset, then rerun.
        @(posedge clk); #1;
        block = PT; keylen = 1'b0; next = 1'b1;
        @(posedge clk); #1;
        next = 1'b0;
        repeat (30) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("abort_ready", 128'(ready), 128'd1);
        check("abort_round", 128'(round), 128'd0);
        check("abort_block", new_block, 128'd0);
        run_op("c1_rerun", KEY_C1, 1'b0, PT, CT_C1, 0, 1'b0);

        // Back-to-back with next held high: 52-cycle period, ready high once per period.
        @(posedge clk); #1;
        block = PT; keylen = 1'b0; next = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 103; k++) begin
            int ph;
            int exp_round;
            @(posedge clk); #1;
            ph = k % 52;
            exp_round = (ph == 0) ? 0 : (1 + (ph - 1) / 5 > 10 ? 10 : 1 + (ph - 1) / 5);
            check($sformatf("b2b_ready_%0d", k), 128'(ready), 128'(ph == 51));
            check($sformatf("b2b_round_%0d", k), 128'(round), 128'(exp_round));
            if (ph == 51) check($sformatf("b2b_result_%0d", k), new_block, CT_C1);
        end
        next = 1'b0;

        for (int n = 0; n < 6; n++) begin
            logic [255:0] key;
            logic [127:0] pt;
            bit           kl;
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            kl  = 1'($urandom_range(0, 1));
            expand_key(key, kl);
            run_op($sformatf("rand%0d", n), key, kl, pt, aes_ref(pt, kl ? 14 : 10),
                   $urandom_range(0, 40), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
